// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and load/store traffic onto one single-port memory,
// one transaction outstanding at a time, with a starvation guard for fetch.
module mem_arbiter (
    input  logic        Clk,
    input  logic        Rst,

    input  logic        IfReq,
    input  logic [63:0] IfAddr,
    output logic        IfValid,
    output logic [31:0] IfInst,

    input  logic        LsReq,
    input  logic        LsWe,
    input  logic [63:0] LsAddr,
    input  logic [63:0] LsWdata,
    input  logic [7:0]  LsWmask,
    output logic        LsValid,
    output logic [63:0] LsRdata,

    input  logic        JumpFlag,

    output logic        IfStall,
    output logic        LsStall,

    output logic        MemReq,
    output logic        MemWe,
    output logic [63:0] MemAddr,
    output logic [63:0] MemWdata,
    output logic [7:0]  MemWmask,
    input  logic        MemAck,
    input  logic [63:0] MemRdata
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] IF_BUSY = 2'd1;
    localparam logic [1:0] LS_BUSY = 2'd2;

    logic [1:0]  state_q,     state_d;
    logic [1:0]  ls_streak_q, ls_streak_d;
    logic        drop_if_q,   drop_if_d;

    logic        mem_req_q,   mem_req_d;
    logic        mem_we_q,    mem_we_d;
    logic [63:0] mem_addr_q,  mem_addr_d;
    logic [63:0] mem_wdata_q, mem_wdata_d;
    logic [7:0]  mem_wmask_q, mem_wmask_d;

    logic        if_valid_q,  if_valid_d;
    logic        ls_valid_q,  ls_valid_d;
    logic [31:0] if_inst_q,   if_inst_d;
    logic [63:0] ls_rdata_q,  ls_rdata_d;

    logic        starve;
    logic        ls_grant;
    logic        if_grant;

    // Three back-to-back load/store grants while fetch waits hand the next slot to fetch.
    assign starve   = (ls_streak_q == 2'd3) && IfReq;
    assign ls_grant = (state_q == IDLE) && LsReq && !starve;
    assign if_grant = (state_q == IDLE) && IfReq && !ls_grant;

    always_comb begin
        // NOTE: every next-state signal gets a default here so no path infers a latch.
        state_d     = state_q;
        ls_streak_d = ls_streak_q;
        drop_if_d   = drop_if_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        if_valid_d  = 1'b0;
        ls_valid_d  = 1'b0;
        if_inst_d   = if_inst_q;
        ls_rdata_d  = ls_rdata_q;

        case (state_q)
            IDLE: begin
                if (ls_grant) begin
                    state_d     = LS_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = LsWe;
                    mem_addr_d  = LsAddr;
                    mem_wdata_d = LsWdata;
                    mem_wmask_d = LsWmask;
                end else if (if_grant) begin
                    state_d     = IF_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = IfAddr;
                    mem_wdata_d = 64'd0;
                    mem_wmask_d = 8'd0;
                end
            end

            IF_BUSY: begin
                if (MemAck) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    drop_if_d = 1'b0;
                    // A flush seen at any point of the fetch, including the ack cycle, kills its response.
                    if (!drop_if_q && !JumpFlag) begin
                        if_valid_d = 1'b1;
                        if_inst_d  = MemRdata[31:0];
                    end
                end else if (JumpFlag) begin
                    drop_if_d = 1'b1;
                end
            end

            LS_BUSY: begin
                if (MemAck) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    ls_valid_d = 1'b1;
                    if (!mem_we_q) begin
                        ls_rdata_d = MemRdata;
                    end
                end
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        if (if_grant || !IfReq) begin
            ls_streak_d = 2'd0;
        end else if (ls_grant && (ls_streak_q != 2'd3)) begin
            ls_streak_d = ls_streak_q + 2'd1;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= IDLE;
            ls_streak_q <= 2'd0;
            drop_if_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 64'd0;
            mem_wdata_q <= 64'd0;
            mem_wmask_q <= 8'd0;
            if_valid_q  <= 1'b0;
            ls_valid_q  <= 1'b0;
            if_inst_q   <= 32'd0;
            ls_rdata_q  <= 64'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers sample together.
            state_q     <= state_d;
            ls_streak_q <= ls_streak_d;
            drop_if_q   <= drop_if_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            if_valid_q  <= if_valid_d;
            ls_valid_q  <= ls_valid_d;
            if_inst_q   <= if_inst_d;
            ls_rdata_q  <= ls_rdata_d;
        end
    end

    assign MemReq   = mem_req_q;
    assign MemWe    = mem_we_q;
    assign MemAddr  = mem_addr_q;
    assign MemWdata = mem_wdata_q;
    assign MemWmask = mem_wmask_q;

    assign IfValid  = if_valid_q;
    assign IfInst   = if_inst_q;
    assign LsValid  = ls_valid_q;
    assign LsRdata  = ls_rdata_q;

    assign IfStall  = IfReq & ~if_valid_q;
    assign LsStall  = LsReq & ~ls_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by randomized
// traffic, all compared cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        IfReq;
    logic [63:0] IfAddr;
    logic        IfValid;
    logic [31:0] IfInst;
    logic        LsReq;
    logic        LsWe;
    logic [63:0] LsAddr;
    logic [63:0] LsWdata;
    logic [7:0]  LsWmask;
    logic        LsValid;
    logic [63:0] LsRdata;
    logic        JumpFlag;
    logic        IfStall;
    logic        LsStall;
    logic        MemReq;
    logic        MemWe;
    logic [63:0] MemAddr;
    logic [63:0] MemWdata;
    logic [7:0]  MemWmask;
    logic        MemAck;
    logic [63:0] MemRdata;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    mem_arbiter dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .IfReq    (IfReq),
        .IfAddr   (IfAddr),
        .IfValid  (IfValid),
        .IfInst   (IfInst),
        .LsReq    (LsReq),
        .LsWe     (LsWe),
        .LsAddr   (LsAddr),
        .LsWdata  (LsWdata),
        .LsWmask  (LsWmask),
        .LsValid  (LsValid),
        .LsRdata  (LsRdata),
        .JumpFlag (JumpFlag),
        .IfStall  (IfStall),
        .LsStall  (LsStall),
        .MemReq   (MemReq),
        .MemWe    (MemWe),
        .MemAddr  (MemAddr),
        .MemWdata (MemWdata),
        .MemWmask (MemWmask),
        .MemAck   (MemAck),
        .MemRdata (MemRdata)
    );

    // Reference model: the transaction currently owning the memory plus response history.
    typedef struct {
        bit          busy;
        bit          fetch;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } txn_t;

    txn_t        cur;
    int          streak;
    bit          drop;
    bit          e_ifv;
    bit          e_lsv;
    logic [31:0] e_inst;
    logic [63:0] e_rdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        cur     = '{busy: 1'b0, fetch: 1'b0, we: 1'b0, addr: 64'd0, wdata: 64'd0, wmask: 8'd0};
        streak  = 0;
        drop    = 1'b0;
        e_ifv   = 1'b0;
        e_lsv   = 1'b0;
        e_inst  = 32'd0;
        e_rdata = 64'd0;
    endtask

    // Applies the arbitration rules to the inputs present at one rising edge.
    task automatic model_edge();
        bit n_ifv = 1'b0;
        bit n_lsv = 1'b0;
        if (cur.busy) begin
            if (MemAck) begin
                if (cur.fetch) begin
                    if (!drop && !JumpFlag) begin
                        n_ifv  = 1'b1;
                        e_inst = MemRdata[31:0];
                    end
                end else begin
                    n_lsv = 1'b1;
                    if (!cur.we) e_rdata = MemRdata;
                end
                cur.busy = 1'b0;
                drop     = 1'b0;
            end else if (cur.fetch && JumpFlag) begin
                drop = 1'b1;
            end
            if (!IfReq) streak = 0;
        end else if (LsReq && !(streak == 3 && IfReq)) begin
            cur    = '{busy: 1'b1, fetch: 1'b0, we: LsWe, addr: LsAddr, wdata: LsWdata, wmask: LsWmask};
            streak = IfReq ? ((streak < 3) ? streak + 1 : 3) : 0;
        end else if (IfReq) begin
            cur    = '{busy: 1'b1, fetch: 1'b1, we: 1'b0, addr: IfAddr, wdata: 64'd0, wmask: 8'd0};
            streak = 0;
        end else begin
            streak = 0;
        end
        e_ifv = n_ifv;
        e_lsv = n_lsv;
    endtask

    task automatic compare_regs();
        check("mem_req", MemReq, cur.busy);
        if (cur.busy) begin
            check("mem_addr",  MemAddr,  cur.addr);
            check("mem_we",    MemWe,    cur.we);
            check("mem_wdata", MemWdata, cur.wdata);
            check("mem_wmask", MemWmask, cur.wmask);
        end
        check("if_valid",  IfValid, e_ifv);
        check("ls_valid",  LsValid, e_lsv);
        check("if_inst",   IfInst,  e_inst);
        check("ls_rdata",  LsRdata, e_rdata);
        check("one_valid", IfValid & LsValid, 1'b0);
    endtask

    // One clock: stalls checked against current inputs, then the edge, then registered outputs.
    task automatic cycle();
        #1;
        check("if_stall", IfStall, IfReq & ~e_ifv);
        check("ls_stall", LsStall, LsReq & ~e_lsv);
        @(posedge Clk);
        model_edge();
        #1;
        compare_regs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] saved;
        logic        prev_req;
        byte         grants[$];
        string       exp_grants;
        int          vcount;
        int          last;
        bit          jump_prev;

        Rst = 1'b1; IfReq = 1'b0; IfAddr = '0; LsReq = 1'b0; LsWe = 1'b0;
        LsAddr = '0; LsWdata = '0; LsWmask = '0; JumpFlag = 1'b0; MemAck = 1'b0; MemRdata = '0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check("rst_mem_req",   MemReq,   1'b0);
        check("rst_mem_we",    MemWe,    1'b0);
        check("rst_mem_addr",  MemAddr,  64'd0);
        check("rst_mem_wdata", MemWdata, 64'd0);
        check("rst_mem_wmask", MemWmask, 8'd0);
        check("rst_if_valid",  IfValid,  1'b0);
        check("rst_ls_valid",  LsValid,  1'b0);
        check("rst_if_inst",   IfInst,   32'd0);
        check("rst_ls_rdata",  LsRdata,  64'd0);
        Rst = 1'b0;

        // Single fetch, ack three cycles after the request reaches memory.
        IfReq = 1'b1; IfAddr = 64'h8000_0000;
        cycle();
        check("fetch_addr", MemAddr, 64'h8000_0000);
        check("fetch_we",   MemWe,   1'b0);
        repeat (3) cycle();
        MemAck = 1'b1; MemRdata = 64'h0000_0000_0000_0013;
        cycle();
        check("fetch_valid", IfValid, 1'b1);
        check("fetch_inst",  IfInst,  32'h0000_0013);
        IfReq = 1'b0; MemAck = 1'b0;
        cycle();
        check("fetch_pulse", IfValid, 1'b0);

        // Simultaneous store and fetch: store goes first.
        IfReq = 1'b1; IfAddr = 64'h8000_0004;
        LsReq = 1'b1; LsWe = 1'b1; LsAddr = 64'h100; LsWdata = 64'hDEAD; LsWmask = 8'hFF;
        saved = LsRdata;
        cycle();
        check("st_we",    MemWe,    1'b1);
        check("st_addr",  MemAddr,  64'h100);
        check("st_wdata", MemWdata, 64'hDEAD);
        check("st_wmask", MemWmask, 8'hFF);
        MemAck = 1'b1; MemRdata = 64'h1234_5678_9ABC_DEF0;
        cycle();
        check("st_valid", LsValid, 1'b1);
        check("st_rdata", LsRdata, saved);
        LsReq = 1'b0; MemAck = 1'b0;
        cycle();
        check("st_if_req",  MemReq,  1'b1);
        check("st_if_addr", MemAddr, 64'h8000_0004);
        MemAck = 1'b1; MemRdata = 64'h0010_0073;
        cycle();
        check("st_if_valid", IfValid, 1'b1);
        IfReq = 1'b0; MemAck = 1'b0;
        cycle();

        // Fairness: continuous loads with a waiting fetch.
        IfReq = 1'b1; IfAddr = 64'h8000_0100;
        LsReq = 1'b1; LsWe = 1'b0; LsAddr = 64'h200; LsWdata = '0; LsWmask = '0;
        for (int i = 0; i < 16; i++) begin
            MemAck = MemReq; MemRdata = {$urandom, $urandom};
            prev_req = MemReq;
            cycle();
            if (MemReq && !prev_req) grants.push_back((MemAddr == 64'h8000_0100) ? "I" : "L");
        end
        exp_grants = "LLLILLLI";
        check("fair_count", grants.size(), 8);
        for (int i = 0; i < 8 && i < grants.size(); i++) check("fair_grant", grants[i], exp_grants[i]);
        IfReq = 1'b0; LsReq = 1'b0;
        repeat (3) begin MemAck = MemReq; cycle(); end
        MemAck = 1'b0;

        // Flush during a fetch drops its response; the redirected fetch completes.
        IfReq = 1'b1; IfAddr = 64'h8000_0200;
        cycle();
        JumpFlag = 1'b1;
        cycle();
        JumpFlag = 1'b0; MemAck = 1'b1; MemRdata = 64'hBAD;
        cycle();
        check("jump_drop", IfValid, 1'b0);
        IfAddr = 64'h8000_0300; MemAck = 1'b0;
        cycle();
        check("jump_req",  MemReq,  1'b1);
        check("jump_addr", MemAddr, 64'h8000_0300);
        MemAck = 1'b1; MemRdata = 64'h93;
        cycle();
        check("jump_valid", IfValid, 1'b1);
        check("jump_inst",  IfInst,  32'h93);
        IfReq = 1'b0; MemAck = 1'b0;
        cycle();

        // Reset in the middle of a load abandons it; a late ack is ignored.
        LsReq = 1'b1; LsWe = 1'b0; LsAddr = 64'h300;
        cycle();
        check("rst_ls_busy", MemReq, 1'b1);
        #1 Rst = 1'b1;
        #1;
        check("rst_async_req", MemReq,  1'b0);
        check("rst_async_lsv", LsValid, 1'b0);
        model_reset();
        @(posedge Clk);
        #1;
        Rst = 1'b0; LsReq = 1'b0; MemAck = 1'b1; MemRdata = 64'h5555;
        cycle();
        check("late_ack_lsv", LsValid, 1'b0);
        check("late_ack_req", MemReq,  1'b0);
        MemAck = 1'b0;
        cycle();

        // Zero-wait memory with back-to-back fetches.
        IfReq = 1'b1; IfAddr = 64'h8000_1000; vcount = 0; last = -1;
        for (int i = 0; i < 20; i++) begin
            MemAck = MemReq;
            MemRdata = {32'h0, IfAddr[31:0] ^ 32'h5A5A_5A5A};
            cycle();
            if (IfValid) begin
                vcount++;
                if (last >= 0) check("zw_gap", i - last, 2);
                check("zw_inst", IfInst, IfAddr[31:0] ^ 32'h5A5A_5A5A);
                IfAddr = IfAddr + 64'd4;
                last = i;
            end
        end
        check("zw_count", vcount, 10);
        IfReq = 1'b0;
        repeat (2) begin MemAck = MemReq; cycle(); end

        // Randomized traffic: random memory latency, spurious acks, flushes.
        jump_prev = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!IfReq) begin
                if ($urandom_range(2) == 0) begin
                    IfReq = 1'b1; IfAddr = {32'h0, $urandom} & ~64'h3;
                end
            end else if (IfValid || jump_prev) begin
                if ($urandom_range(3) == 0) IfReq = 1'b0;
                else IfAddr = {32'h0, $urandom} & ~64'h3;
            end
            if (!LsReq) begin
                if ($urandom_range(2) == 0) begin
                    LsReq = 1'b1; LsWe = $urandom_range(1);
                    LsAddr = {$urandom, $urandom}; LsWdata = {$urandom, $urandom};
                    LsWmask = 8'($urandom);
                end
            end else if (LsValid) begin
                if ($urandom_range(3) == 0) LsReq = 1'b0;
                else begin
                    LsWe = $urandom_range(1);
                    LsAddr = {$urandom, $urandom}; LsWdata = {$urandom, $urandom};
                    LsWmask = 8'($urandom);
                end
            end
            JumpFlag = ($urandom_range(5) == 0);
            jump_prev = JumpFlag;
            MemAck = MemReq ? ($urandom_range(99) < 45) : ($urandom_range(9) == 0);
            MemRdata = {$urandom, $urandom};
            cycle();
        end

        IfReq = 1'b0; LsReq = 1'b0; JumpFlag = 1'b0;
        repeat (4) begin MemAck = MemReq; cycle(); end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL declare ports: Clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL declare: Rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL declare: IfReq  in  1  fetch request, held until IfValid; IfAddr  in  64  fetch address.
REQ-004 SHALL declare: IfValid  out  1  one-cycle fetch response; IfInst  out  32  fetched instruction (MemRdata[31:0]).
REQ-005 SHALL declare: LsReq  in  1  load/store request, held until LsValid; LsWe  in  1  store when 1; LsAddr  in  64; LsWdata  in  64; LsWmask  in  8  byte enables.
REQ-006 SHALL declare: LsValid  out  1  one-cycle load/store completion; LsRdata  out  64  load data.
REQ-007 SHALL declare: JumpFlag  in  1  pipeline flush from Ctrl.
REQ-008 SHALL declare: IfStall  out  1; LsStall  out  1  stall indications to the pipeline.
REQ-009 SHALL declare: MemReq  out  1; MemWe  out  1; MemAddr  out  64; MemWdata  out  64; MemWmask  out  8  shared single-port memory request.
REQ-010 SHALL declare: MemAck  in  1  memory completion pulse; MemRdata  in  64  valid when MemAck=1.

Function
REQ-011 SHALL implement states IDLE, IF_BUSY, LS_BUSY; exactly one memory transaction outstanding.
REQ-012 IDLE: if LsReq and not starvation override -> LS_BUSY; else if IfReq -> IF_BUSY; else stay.
REQ-013 On entering a BUSY state SHALL register MemReq=1 with the granted requester's address/we/wdata/wmask (IF: MemWe=0, MemWmask=0, MemWdata=0); fields constant until MemAck.
REQ-014 BUSY: MemAck=1 -> IDLE, MemReq=0 next cycle; MemAck=0 -> hold.
REQ-015 IfValid/LsValid SHALL pulse 1 cycle after MemAck of the owning transaction; IfInst/LsRdata registered from MemRdata at that edge and held until next response.
REQ-016 Minimum latency: request cycle N -> MemReq cycle N+1 -> MemAck cycle N+1 -> Valid cycle N+2.
REQ-017 Store completion SHALL pulse LsValid; LsRdata unchanged on store.
REQ-018 Fairness: 2-bit LsStreak increments on each LS grant while IfReq=1, saturates at 3, clears on IF grant or IfReq=0; LsStreak=3 with IfReq=1 in IDLE -> grant IF.
REQ-019 JumpFlag=1 in IF_BUSY SHALL set DropIf; the ack of that transaction SHALL NOT produce IfValid; DropIf clears on that ack.
REQ-020 JumpFlag SHALL NOT affect LS_BUSY or LS responses; JumpFlag in IDLE has no effect on arbitration.
REQ-021 JumpFlag in the MemAck cycle of IF_BUSY SHALL suppress IfValid.
REQ-022 MemAck in IDLE SHALL be ignored (no Valid, no state change).
REQ-023 IfStall = IfReq & ~IfValid; LsStall = LsReq & ~LsValid (combinational).
REQ-024 IfValid and LsValid SHALL never be 1 in the same cycle.

Reset
REQ-025 Rst=1 SHALL immediately force IDLE, MemReq=0, MemWe=0, MemAddr=0, MemWdata=0, MemWmask=0, IfValid=0, LsValid=0, IfInst=0, LsRdata=0, LsStreak=0, DropIf=0.
REQ-026 Reset mid-transaction SHALL abandon it; a late MemAck after reset release SHALL be ignored per REQ-022.

Verification
REQ-027 IfReq=1, IfAddr=0x8000_0000, MemAck 3 cycles after MemReq, MemRdata=0x00000013 -> MemAddr=0x8000_0000, MemWe=0; IfValid 1 cycle after ack, IfInst=0x00000013.
REQ-028 IfReq and LsReq (LsWe=1, LsAddr=0x100, LsWdata=0xDEAD, LsWmask=0xFF) same cycle in IDLE -> store issued first, LsValid pulses, then fetch issued; IfValid follows.
REQ-029 LsReq held continuously with IfReq=1, MemAck immediate -> after 3 consecutive LS grants, 4th grant goes to IF; LsStreak returns to 0.
REQ-030 JumpFlag pulsed in IF_BUSY before MemAck -> no IfValid for that ack; next IF request (new IfAddr) completes normally.
REQ-031 Rst asserted in LS_BUSY -> MemReq=0 in same cycle; MemAck after release -> no LsValid, state IDLE.
REQ-032 Zero-wait memory (MemAck same cycle as MemReq), back-to-back IF requests -> IfValid every 2 cycles, no lost or duplicated responses.
